riscv_core_icache_axi_refill: RTL and testbench



---
 rtl/riscv_core_icache_axi_refill.sv | 124 ++++++++++++
 tb/tb_riscv_core_icache_axi_refill.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_icache_axi_refill.sv
// riscv_core_icache_axi_refill
//
// AXI4 read master that refills one instruction-cache line per request.
// A request from the icache controller is turned into a single INCR burst
// of BEATS = LINE_WIDTH/AXI_DATA_WIDTH beats; the returned beats are packed
// into o_line_data (beat 0 in the least significant slice) and completion
// is signalled with a one-cycle o_mem_done pulse.
//
// Ports:
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_mem_req, i_mem_addr    refill request and line address from controller
//   o_mem_done, o_line_data  completion pulse and assembled line
//   o_bus_err                error flag, valid with o_mem_done
//   o_ar*, i_arready         AXI read-address channel (constant burst shape)
//   i_r*, o_rready           AXI read-data channel
module riscv_core_icache_axi_refill #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned LINE_WIDTH     = 256,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter logic [3:0]  AXI_ID         = 4'h0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mem_req,
  input  logic [ADDR_WIDTH-1:0]     i_mem_addr,
  output logic                      o_mem_done,
  output logic [LINE_WIDTH-1:0]     o_line_data,
  output logic                      o_bus_err,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic [3:0]                o_arid,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast
);

  localparam int unsigned BEATS  = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned ARSIZE = $clog2(AXI_DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             beat;
  logic             last_beat;

  // Burst shape never changes: one full line, INCR, fixed ID.
  assign o_arlen   = 8'(BEATS - 1);
  assign o_arsize  = 3'(ARSIZE);
  assign o_arburst = 2'b01;
  assign o_arid    = AXI_ID;

  // Handshake outputs decode the state register only.
  assign o_arvalid  = (state == S_ADDR);
  assign o_rready   = (state == S_DATA);
  assign o_mem_done = (state == S_DONE);
  assign o_bus_err  = (state == S_DONE) && err;

  assign beat      = (state == S_DATA) && i_rvalid;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The beat counter, not i_rlast, decides when the burst ends.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (i_mem_req) state_next = S_ADDR;
      S_ADDR: if (i_arready) state_next = S_DATA;
      S_DATA: if (beat && last_beat) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_araddr    <= '0;
      o_line_data <= '0;
      cnt         <= '0;
      err         <= 1'b0;
    end else begin
      if (state == S_IDLE && i_mem_req) begin
        o_araddr <= {i_mem_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        cnt      <= '0;
        err      <= 1'b0;
      end
      if (beat) begin
        for (int unsigned b = 0; b < BEATS; b++) begin
          if (cnt == CNT_W'(b)) begin
            o_line_data[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
          end
        end
        cnt <= cnt + 1'b1;
        // Slave error, or RLAST disagreeing with our own beat count.
        if (i_rresp[1] || (i_rlast != last_beat)) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_icache_axi_refill.sv
module tb_riscv_core_icache_axi_refill;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_mem_req;
  logic [63:0]  i_mem_addr;
  logic         o_mem_done;
  logic [255:0] o_line_data;
  logic         o_bus_err;
  logic         o_arvalid;
  logic         i_arready;
  logic [63:0]  o_araddr;
  logic [7:0]   o_arlen;
  logic [2:0]   o_arsize;
  logic [1:0]   o_arburst;
  logic [3:0]   o_arid;
  logic         i_rvalid;
  logic         o_rready;
  logic [63:0]  i_rdata;
  logic [1:0]   i_rresp;
  logic         i_rlast;

  riscv_core_icache_axi_refill #(
    .ADDR_WIDTH(64),
    .LINE_WIDTH(256),
    .AXI_DATA_WIDTH(64),
    .AXI_ID(4'h0)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_mem_req(i_mem_req),
    .i_mem_addr(i_mem_addr),
    .o_mem_done(o_mem_done),
    .o_line_data(o_line_data),
    .o_bus_err(o_bus_err),
    .o_arvalid(o_arvalid),
    .i_arready(i_arready),
    .o_araddr(o_araddr),
    .o_arlen(o_arlen),
    .o_arsize(o_arsize),
    .o_arburst(o_arburst),
    .o_arid(o_arid),
    .i_rvalid(i_rvalid),
    .o_rready(o_rready),
    .i_rdata(i_rdata),
    .i_rresp(i_rresp),
    .i_rlast(i_rlast)
  );

  always #5 i_clk = ~i_clk;

  int           vectors = 0;
  int           miscompares = 0;
  logic [63:0]  words [4];
  logic [255:0] exp_line = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_arvalid"}, o_arvalid, 0);
    chk({tag, "_rready"}, o_rready, 0);
    chk({tag, "_done"}, o_mem_done, 0);
    chk({tag, "_bus_err"}, o_bus_err, 0);
    chk({tag, "_araddr"}, o_araddr, 0);
    chk({tag, "_line"}, o_line_data, 0);
  endtask

  // Slave + reference model: the expected line is the four words packed
  // beat 0 lowest; the expected error is any RRESP[1] or any beat whose
  // RLAST disagrees with "this is beat 3". Gap < 0 picks random gaps.
  task automatic refill(input logic [63:0] addr, input int arw, input int gap,
                        input int errb, input int lastb);
    logic [255:0] nl;
    logic [63:0]  ea;
    bit           ee;
    int           g;
    ea = (addr / 32) * 32;
    nl = exp_line;
    ee = 0;
    i_mem_req  = 1'b1;
    i_mem_addr = addr;
    i_arready  = 1'b0;
    i_rvalid   = 1'b0;
    step();
    chk("arvalid", o_arvalid, 1);
    chk("araddr", o_araddr, ea);
    chk("arlen", o_arlen, 3);
    chk("arsize", o_arsize, 3);
    chk("arburst", o_arburst, 1);
    chk("arid", o_arid, 0);
    chk("line_hold_addr", o_line_data, exp_line);
    for (int k = 0; k < arw; k++) begin
      step();
      chk("arvalid_wait", o_arvalid, 1);
      chk("araddr_stable", o_araddr, ea);
      chk("rready_in_addr", o_rready, 0);
    end
    i_arready = 1'b1;
    step();
    i_arready = 1'b0;
    chk("rready", o_rready, 1);
    chk("arvalid_after_hs", o_arvalid, 0);
    chk("line_hold_data", o_line_data, exp_line);
    for (int b = 0; b < 4; b++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (b == 0) g = 0;
      for (int k = 0; k < g; k++) begin
        step();
        chk("rready_gap", o_rready, 1);
        chk("done_early_gap", o_mem_done, 0);
      end
      i_rvalid = 1'b1;
      i_rdata  = words[b];
      i_rresp  = {(b == errb), 1'($urandom_range(0, 1))};
      i_rlast  = (b == lastb);
      nl[b*64 +: 64] = words[b];
      if (b == errb || ((b == lastb) != (b == 3))) ee = 1;
      step();
      i_rvalid = 1'b0;
      i_rlast  = 1'b0;
      i_rresp  = 2'b00;
      if (b < 3) chk("done_early_beat", o_mem_done, 0);
    end
    chk("mem_done", o_mem_done, 1);
    chk("bus_err", o_bus_err, ee);
    chk("line", o_line_data, nl);
    exp_line  = nl;
    i_mem_req = 1'b0;
    step();
    chk("done_single", o_mem_done, 0);
    chk("bus_err_low", o_bus_err, 0);
    chk("line_after_done", o_line_data, nl);
    chk("arvalid_idle", o_arvalid, 0);
  endtask

  task automatic rand_words();
    for (int b = 0; b < 4; b++) words[b] = {$urandom, $urandom};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout no summary reached");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1; i_mem_req = 1'b0; i_mem_addr = '0; i_arready = 1'b0;
    i_rvalid = 1'b0; i_rdata = '0; i_rresp = 2'b00; i_rlast = 1'b0;
    step();
    step();
    all_zero("reset");
    i_rst = 1'b0;
    step();
    all_zero("post_reset");

    // Basic refill, zero wait.
    words[0] = 64'h1111_1111_1111_1111; words[1] = 64'h2222_2222_2222_2222;
    words[2] = 64'h3333_3333_3333_3333; words[3] = 64'h4444_4444_4444_4444;
    refill(64'h0000_0000_0000_1234, 0, 0, -1, 3);
    chk("basic_line_const", o_line_data,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Backpressure: 3 AR wait cycles, 2-cycle gaps between beats.
    rand_words();
    refill({$urandom, $urandom}, 3, 2, -1, 3);

    // Slave error on beat 2, then a clean refill.
    rand_words();
    refill(64'h0000_0000_0000_2040, 0, 0, 2, 3);
    rand_words();
    refill(64'h0000_0000_0000_2060, 0, 0, -1, 3);

    // RLAST early on beat 1.
    rand_words();
    refill(64'h0000_0000_0000_3000, 1, 0, -1, 1);

    // Reset mid-burst after beat 1.
    rand_words();
    i_mem_req = 1'b1; i_mem_addr = 64'h4000;
    step();
    i_arready = 1'b1;
    step();
    i_arready = 1'b0;
    i_rvalid = 1'b1; i_rdata = words[0];
    step();
    i_rdata = words[1];
    step();
    i_rdata = words[2];
    #2 i_rst = 1'b1;
    #1 all_zero("mid_reset");
    step();
    i_mem_req = 1'b0;
    i_rst = 1'b0;
    step();
    chk("late_beat_rready", o_rready, 0);
    chk("late_beat_line", o_line_data, 0);
    chk("late_beat_done", o_mem_done, 0);
    step();
    chk("late_beat_done2", o_mem_done, 0);
    i_rvalid = 1'b0;
    exp_line = '0;
    rand_words();
    refill(64'h0000_0000_0000_4000, 0, 0, -1, 3);

    // Consecutive lines across a 4 KiB boundary.
    rand_words();
    refill(64'h0000_0000_0000_0FE0, 0, 1, -1, 3);
    rand_words();
    refill(64'h0000_0000_0000_1000, 0, 0, -1, 3);

    // Randomized refills.
    for (int i = 0; i < 10; i++) begin
      int eb;
      int lb;
      rand_words();
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      lb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : 3;
      refill({$urandom, $urandom}, int'($urandom_range(0, 3)), -1, eb, lb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
